// File: rtl/interrupt_pkg.sv
// Shared constants and types for the machine-level interrupt arbiter.
// Cause codes, PLIC register addresses and the request FSM states.
package interrupt_pkg;

   localparam logic [4:0] CAUSE_MSI = 5'd3;
   localparam logic [4:0] CAUSE_MTI = 5'd7;
   localparam logic [4:0] CAUSE_MEI = 5'd11;

   localparam logic [31:0] PLIC_PRIO_BASE   = 32'h0C00_0000;
   localparam logic [31:0] PLIC_ENABLE_ADDR = 32'h0C00_2000;
   localparam logic [31:0] PLIC_THRESH_ADDR = 32'h0C20_0000;
   localparam logic [31:0] PLIC_CLAIM_ADDR  = 32'h0C20_0004;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/interrupt_arbiter_plic_select.sv
// Combinational external-source selector: highest priority above
// threshold wins, ties resolved toward the lowest source ID.
module plic_select #(
   parameter int N      = 16,
   parameter int PRIO_W = 3,
   parameter int ID_W   = 4
) (
   input  logic [N-1:0]             enable_i,
   input  logic [N-1:0]             pending_i,
   input  logic [N-1:0][PRIO_W-1:0] prio_i,
   input  logic [PRIO_W-1:0]        threshold_i,
   output logic                     valid_o,
   output logic [ID_W-1:0]          id_o
);

   logic [PRIO_W-1:0] best;

   // Strict '>' against the running best keeps the lower ID on ties;
   // priority 0 can never exceed the threshold, so source 0 never wins.
   always_comb begin
      valid_o = 1'b0;
      id_o    = '0;
      best    = '0;
      for (int i = 0; i < N; i++) begin
         if (enable_i[i] && pending_i[i] &&
             (prio_i[i] > threshold_i) &&
             (!valid_o || (prio_i[i] > best))) begin
            valid_o = 1'b1;
            id_o    = ID_W'(i);
            best    = prio_i[i];
         end
      end
   end

endmodule

// File: rtl/interrupt_arbiter.sv
// Machine-level interrupt arbiter: merges CLINT levels with PLIC-style
// external sources and drives a single request with ack/complete tracking.
module interrupt_arbiter
   import interrupt_pkg::*;
#(
   parameter int PLIC_NUM_SOURCES = 16,
   parameter int PRIO_W           = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clint_timer_irq_i,
   input  logic                        clint_software_irq_i,
   input  logic [PLIC_NUM_SOURCES-1:0] plic_irq_sources_i,
   input  logic                        cfg_en,
   input  logic                        cfg_we,
   input  logic [31:0]                 cfg_addr,
   input  logic [31:0]                 cfg_wdata,
   output logic [31:0]                 cfg_rdata,
   output logic                        cfg_ready,
   output logic                        irq_o,
   output logic [4:0]                  irq_cause_o,
   output logic [31:0]                 irq_extra_o,
   input  logic                        irq_ack_i,
   input  logic                        irq_complete_i
);

   localparam int N    = PLIC_NUM_SOURCES;
   localparam int ID_W = $clog2(N);

   logic [N-1:0][PRIO_W-1:0] prio_q, prio_d;
   logic [N-1:0]             enable_q, enable_d;
   logic [PRIO_W-1:0]        thresh_q, thresh_d;
   logic [N-1:0]             pending_q, pending_d;
   logic [N-1:0]             claimed_q, claimed_d;
   arb_state_t               state_q, state_d;
   logic                     irq_q, irq_d;
   logic [4:0]               cause_q, cause_d;
   logic [31:0]              extra_q, extra_d;
   logic                     cfg_ready_q, cfg_ready_d;
   logic [31:0]              cfg_rdata_q, cfg_rdata_d;
   logic                     cfg_wait_q, cfg_wait_d;

   logic            acc;
   logic [31:0]     prio_off;
   logic            prio_hit;
   logic [ID_W-1:0] prio_idx;
   logic [31:0]     svc_id;
   logic            ext_valid;
   logic [ID_W-1:0] ext_id;
   logic            cand;
   logic [4:0]      cand_cause;
   logic [31:0]     cand_extra;
   logic [ID_W-1:0] cur_id;

   assign acc      = cfg_en && !cfg_wait_q;
   assign prio_off = cfg_addr - PLIC_PRIO_BASE;
   assign prio_hit = (prio_off < 32'(4 * N)) && (cfg_addr[1:0] == 2'b00);
   assign prio_idx = prio_off[ID_W+1:2];
   assign cur_id   = extra_q[ID_W-1:0];
   assign svc_id   = (state_q == ST_SERVICE && cause_q == CAUSE_MEI)
                     ? extra_q : 32'd0;

   // Config access: one registered ready pulse per accepted request.
   always_comb begin
      prio_d      = prio_q;
      enable_d    = enable_q;
      thresh_d    = thresh_q;
      cfg_ready_d = acc;
      cfg_rdata_d = 32'd0;
      cfg_wait_d  = cfg_wait_q;
      if (acc) begin
         cfg_wait_d = 1'b1;
      end else if (!cfg_en) begin
         cfg_wait_d = 1'b0;
      end
      if (acc && cfg_we) begin
         if (prio_hit && prio_idx != '0) begin
            prio_d[prio_idx] = cfg_wdata[PRIO_W-1:0];
         end else if (cfg_addr == PLIC_ENABLE_ADDR) begin
            enable_d = cfg_wdata[N-1:0] & ~N'(1);
         end else if (cfg_addr == PLIC_THRESH_ADDR) begin
            thresh_d = cfg_wdata[PRIO_W-1:0];
         end
      end else if (acc) begin
         if (prio_hit) begin
            cfg_rdata_d = 32'(prio_q[prio_idx]);
         end else if (cfg_addr == PLIC_ENABLE_ADDR) begin
            cfg_rdata_d = 32'(enable_q);
         end else if (cfg_addr == PLIC_THRESH_ADDR) begin
            cfg_rdata_d = 32'(thresh_q);
         end else if (cfg_addr == PLIC_CLAIM_ADDR) begin
            cfg_rdata_d = svc_id;
         end
      end
   end

   plic_select #(
      .N      (N),
      .PRIO_W (PRIO_W),
      .ID_W   (ID_W)
   ) u_select (
      .enable_i    (enable_q),
      .pending_i   (pending_q),
      .prio_i      (prio_q),
      .threshold_i (thresh_q),
      .valid_o     (ext_valid),
      .id_o        (ext_id)
   );

   always_comb begin
      cand       = 1'b1;
      cand_cause = 5'd0;
      cand_extra = 32'd0;
      if (clint_timer_irq_i) begin
         cand_cause = CAUSE_MTI;
      end else if (clint_software_irq_i) begin
         cand_cause = CAUSE_MSI;
      end else if (ext_valid) begin
         cand_cause = CAUSE_MEI;
         cand_extra = 32'(ext_id);
      end else begin
         cand = 1'b0;
      end
   end

   // Gateway and request FSM share one process: ack/complete move bits
   // between pending and claimed for the latched source ID.
   always_comb begin
      state_d   = state_q;
      irq_d     = irq_q;
      cause_d   = cause_q;
      extra_d   = extra_q;
      claimed_d = claimed_q;
      pending_d = (pending_q | (plic_irq_sources_i & ~claimed_q))
                  & ~N'(1);
      unique case (state_q)
         ST_IDLE: begin
            irq_d   = cand;
            cause_d = cand_cause;
            extra_d = cand_extra;
            if (cand) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (irq_ack_i) begin
               state_d = ST_SERVICE;
               irq_d   = 1'b0;
               if (cause_q == CAUSE_MEI) begin
                  pending_d[cur_id] = 1'b0;
                  claimed_d[cur_id] = 1'b1;
               end
            end else begin
               irq_d   = cand;
               cause_d = cand_cause;
               extra_d = cand_extra;
               if (!cand) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_SERVICE: begin
            irq_d = 1'b0;
            if (irq_complete_i) begin
               state_d = ST_IDLE;
               cause_d = 5'd0;
               extra_d = 32'd0;
               if (cause_q == CAUSE_MEI) begin
                  claimed_d[cur_id] = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            irq_d   = 1'b0;
            cause_d = 5'd0;
            extra_d = 32'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_q      <= '0;
         enable_q    <= '0;
         thresh_q    <= '0;
         pending_q   <= '0;
         claimed_q   <= '0;
         state_q     <= ST_IDLE;
         irq_q       <= 1'b0;
         cause_q     <= 5'd0;
         extra_q     <= 32'd0;
         cfg_ready_q <= 1'b0;
         cfg_rdata_q <= 32'd0;
         cfg_wait_q  <= 1'b0;
      end else begin
         prio_q      <= prio_d;
         enable_q    <= enable_d;
         thresh_q    <= thresh_d;
         pending_q   <= pending_d;
         claimed_q   <= claimed_d;
         state_q     <= state_d;
         irq_q       <= irq_d;
         cause_q     <= cause_d;
         extra_q     <= extra_d;
         cfg_ready_q <= cfg_ready_d;
         cfg_rdata_q <= cfg_rdata_d;
         cfg_wait_q  <= cfg_wait_d;
      end
   end

   assign cfg_ready   = cfg_ready_q;
   assign cfg_rdata   = cfg_rdata_q;
   assign irq_o       = irq_q;
   assign irq_cause_o = cause_q;
   assign irq_extra_o = extra_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: scenario tasks with
// expected values queued at stimulus time and popped at DUT response.
module tb_interrupt_arbiter;

   typedef struct packed {
      logic [4:0]  cause;
      logic [31:0] extra;
   } irq_exp_t;

   logic        clk;
   logic        rst;
   logic        timer;
   logic        sw;
   logic [15:0] src;
   logic        cfg_en;
   logic        cfg_we;
   logic [31:0] cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;
   logic        cfg_ready;
   logic        irq_o;
   logic [4:0]  irq_cause;
   logic [31:0] irq_extra;
   logic        ack;
   logic        complete;

   int errors = 0;
   int checks = 0;

   logic [31:0] rd_q[$];
   irq_exp_t    irq_q[$];

   interrupt_arbiter dut (
      .clk                  (clk),
      .rst                  (rst),
      .clint_timer_irq_i    (timer),
      .clint_software_irq_i (sw),
      .plic_irq_sources_i   (src),
      .cfg_en               (cfg_en),
      .cfg_we               (cfg_we),
      .cfg_addr             (cfg_addr),
      .cfg_wdata            (cfg_wdata),
      .cfg_rdata            (cfg_rdata),
      .cfg_ready            (cfg_ready),
      .irq_o                (irq_o),
      .irq_cause_o          (irq_cause),
      .irq_extra_o          (irq_extra),
      .irq_ack_i            (ack),
      .irq_complete_i       (complete)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic ok);
      ok = 1'b0;
      cfg_en = 1'b1;
      cfg_we = we;
      cfg_addr = addr;
      cfg_wdata = wdata;
      for (int i = 0; i < 5; i++) begin
         step();
         if (cfg_ready) begin
            ok = 1'b1;
            break;
         end
      end
      cfg_en = 1'b0;
      cfg_we = 1'b0;
   endtask

   task automatic cfg_write(input logic [31:0] addr, input logic [31:0] d);
      logic ok;
      cfg_access(1'b1, addr, d, ok);
      if (!ok) begin
         errors++;
         $display("FAIL cfg_write_timeout addr=%h got no ready", addr);
      end
      step();
   endtask

   task automatic cfg_read(input string name, input logic [31:0] addr,
                           input logic [31:0] exp);
      logic ok;
      logic [31:0] e;
      rd_q.push_back(exp);
      cfg_access(1'b0, addr, 32'd0, ok);
      e = rd_q.pop_front();
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s timeout: no cfg_ready, wanted rdata=%h", name, e);
      end else if (cfg_rdata !== e) begin
         errors++;
         $display("FAIL %s rdata=%h required %h", name, cfg_rdata, e);
      end
      step();
   endtask

   task automatic wait_irq(input string name, input logic [4:0] cause,
                           input logic [31:0] extra, input int budget);
      logic got;
      irq_exp_t e;
      irq_q.push_back({cause, extra});
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (irq_o === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      e = irq_q.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: irq_o=%b required 1 within %0d",
                  name, irq_o, budget);
      end else if (irq_cause !== e.cause || irq_extra !== e.extra) begin
         errors++;
         $display("FAIL %s cause=%0d extra=%0d required cause=%0d extra=%0d",
                  name, irq_cause, irq_extra, e.cause, e.extra);
      end
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic pulse_complete();
      complete = 1'b1;
      step();
      complete = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({irq_o, irq_cause, irq_extra, cfg_ready, cfg_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs irq=%b cause=%0d extra=%h rdy=%b",
                  irq_o, irq_cause, irq_extra, cfg_ready);
      end
      rst = 1'b0;
      step();
      cfg_read("reset_prio1", 32'h0C00_0004, 32'd0);
      cfg_read("reset_enable", 32'h0C00_2000, 32'd0);
      cfg_read("reset_thresh", 32'h0C20_0000, 32'd0);
   endtask

   task automatic test_config();
      cfg_write(32'h0C00_0000, 32'd7);
      cfg_read("prio0_ro", 32'h0C00_0000, 32'd0);
      cfg_write(32'h0C00_2000, 32'h0000_FFFF);
      cfg_read("enable_bit0", 32'h0C00_2000, 32'h0000_FFFE);
      cfg_write(32'h0C00_003C, 32'hFFFF_FFFD);
      cfg_read("prio15_mask", 32'h0C00_003C, 32'd5);
      cfg_write(32'h0C00_003C, 32'd0);
      cfg_write(32'h0C00_2000, 32'd0);
   endtask

   task automatic test_software();
      sw = 1'b1;
      wait_irq("msi_raise", 5'd3, 32'd0, 2);
      pulse_ack();
      checks++;
      if (irq_o !== 1'b0 || irq_cause !== 5'd3) begin
         errors++;
         $display("FAIL msi_ack irq=%b cause=%0d required irq=0 cause=3",
                  irq_o, irq_cause);
      end
      pulse_complete();
      wait_irq("msi_rereq", 5'd3, 32'd0, 3);
      pulse_ack();
      sw = 1'b0;
      pulse_complete();
      step();
   endtask

   task automatic test_timer_preempt();
      sw = 1'b1;
      wait_irq("pre_msi", 5'd3, 32'd0, 2);
      timer = 1'b1;
      step();
      checks++;
      if (irq_o !== 1'b1 || irq_cause !== 5'd7) begin
         errors++;
         $display("FAIL mti_preempt irq=%b cause=%0d required irq=1 cause=7",
                  irq_o, irq_cause);
      end
      pulse_ack();
      checks++;
      if (irq_o !== 1'b0 || irq_cause !== 5'd7) begin
         errors++;
         $display("FAIL mti_latch irq=%b cause=%0d required irq=0 cause=7",
                  irq_o, irq_cause);
      end
      timer = 1'b0;
      sw = 1'b0;
      pulse_complete();
      step();
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL mti_idle irq=%b required 0", irq_o);
      end
   endtask

   task automatic test_external();
      cfg_write(32'h0C00_0004, 32'd3);
      cfg_write(32'h0C00_2000, 32'h2);
      cfg_write(32'h0C20_0000, 32'd1);
      src[1] = 1'b1;
      wait_irq("ext1_raise", 5'd11, 32'd1, 4);
      pulse_ack();
      cfg_read("ext1_claim", 32'h0C20_0004, 32'd1);
      src[1] = 1'b0;
      pulse_complete();
      cfg_read("ext1_released", 32'h0C20_0004, 32'd0);
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL ext1_no_rereq irq=%b required 0", irq_o);
      end
   endtask

   task automatic test_tie();
      cfg_write(32'h0C00_0008, 32'd4);
      cfg_write(32'h0C00_0014, 32'd4);
      cfg_write(32'h0C00_2000, 32'h26);
      src[2] = 1'b1;
      src[5] = 1'b1;
      wait_irq("tie_low_id", 5'd11, 32'd2, 4);
      pulse_ack();
      src[2] = 1'b0;
      pulse_complete();
      wait_irq("tie_next", 5'd11, 32'd5, 4);
      pulse_ack();
      src[5] = 1'b0;
      pulse_complete();
      step();
   endtask

   task automatic test_threshold();
      cfg_write(32'h0C00_000C, 32'd2);
      cfg_write(32'h0C00_2000, 32'h8);
      cfg_write(32'h0C20_0000, 32'd2);
      src[3] = 1'b1;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL thresh_equal irq=%b required 0", irq_o);
      end
      cfg_write(32'h0C20_0000, 32'd1);
      wait_irq("thresh_below", 5'd11, 32'd3, 4);
      pulse_ack();
      src[3] = 1'b0;
      pulse_complete();
      step();
   endtask

   task automatic test_reset_mid();
      timer = 1'b1;
      wait_irq("mid_raise", 5'd7, 32'd0, 3);
      pulse_ack();
      rst = 1'b1;
      #1;
      checks++;
      if ({irq_o, irq_cause, irq_extra, cfg_ready} !== '0) begin
         errors++;
         $display("FAIL mid_reset irq=%b cause=%0d extra=%h required 0",
                  irq_o, irq_cause, irq_extra);
      end
      timer = 1'b0;
      step();
      rst = 1'b0;
      step();
      cfg_read("mid_prio3", 32'h0C00_000C, 32'd0);
      cfg_read("mid_enable", 32'h0C00_2000, 32'd0);
      cfg_write(32'h0200_0000, 32'hFFFF_FFFF);
      cfg_read("clint_unmapped", 32'h0200_0000, 32'd0);
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_pulse ready=%b required 0", cfg_ready);
      end
   endtask

   initial begin
      rst = 1'b1;
      timer = 1'b0;
      sw = 1'b0;
      src = '0;
      cfg_en = 1'b0;
      cfg_we = 1'b0;
      cfg_addr = '0;
      cfg_wdata = '0;
      ack = 1'b0;
      complete = 1'b0;
      test_reset();
      test_config();
      test_software();
      test_timer_preempt();
      test_external();
      test_tie();
      test_threshold();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
